scan_chain_ctrl: RTL and testbench
==================================

Name: scan_chain_ctrl

Overview:
- Controller that sits at the other end of a chain of CHAIN_LEN mux-scan flops (D0 functional, D1 scan, SD select, CK clock).
- Drives SD and the scan-in bit, and collects the scan-out bit.
- One operation shifts a pattern into the chain while unloading the previous contents. It then performs a single functional capture cycle, and finally shifts the captured state out into a parallel word.
- Used for register-state readback and fault injection on ECP5 designs built from library flops.

Parameters:
- CHAIN_LEN, 16, number of flops in the chain (>= 2).
- CNT_W, $clog2(CHAIN_LEN+1), bit counter width (derived, not overridden).

Ports:
- CK  in  1  clock, rising edge; shared with the chain flops.
- CD  in  1  reset, asynchronous, active-high (clears all state).
- START  in  1  one-cycle request; sampled only in IDLE.
- LOAD_DATA  in  CHAIN_LEN  pattern to shift in; latched on the accepted START.
- SD  out  1  scan select to every chain flop (1 = shift, 0 = functional/capture).
- SI  out  1  scan-in bit, drives D1 of chain position 0.
- SO  in  1  scan-out bit, Q of chain position CHAIN_LEN-1.
- BUSY  out  1  high from the cycle after START is accepted until DONE.
- DONE  out  1  one-cycle pulse; PRE_DATA and CAP_DATA are valid from this cycle.
- PRE_DATA  out  CHAIN_LEN  chain contents before the operation.
- CAP_DATA  out  CHAIN_LEN  chain contents after the capture cycle.

Behaviour:
- Reset (CD=1, asynchronous): state=IDLE, SD=0, SI=0, BUSY=0, DONE=0, PRE_DATA=0, CAP_DATA=0, counter=0, pattern register=0. This holds on any cycle, including mid-shift. The chain contents are left undefined; the controller does not re-initialise them.
- States: IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, FIN.
- IDLE:
  - SD=0.
  - On START=1: latch LOAD_DATA, counter=0, go to SHIFT_IN.
- SHIFT_IN, exactly CHAIN_LEN cycles, k = 0..CHAIN_LEN-1:
  - SD=1 and SI=LOAD_DATA[k], both registered so they are stable for the whole cycle.
  - On the edge ending cycle k: PRE_DATA[k] <= SO.
  - Result: old chain position CHAIN_LEN-1-k lands in PRE_DATA[k], and LOAD_DATA[k] ends at position CHAIN_LEN-1-k.
  - Counter increments each cycle; at k=CHAIN_LEN-1, go to CAPTURE.
- CAPTURE, exactly 1 cycle: SD=0 and SI=0. The chain loads D0 on the edge ending this cycle.
- SHIFT_OUT, exactly CHAIN_LEN cycles:
  - SD=1 and SI=0; CAP_DATA[k] <= SO with the same indexing as SHIFT_IN.
  - The chain ends all-zero.
- FIN, 1 cycle: DONE=1, SD=0. Return to IDLE.
- Latency from the START edge to the DONE pulse: 2*CHAIN_LEN+2 cycles.
- BUSY=1 in SHIFT_IN, CAPTURE and SHIFT_OUT; BUSY=0 in FIN and IDLE.
- START while not in IDLE is ignored; there is no queueing. START in the FIN cycle is also ignored.
- LOAD_DATA changes after acceptance have no effect.
- PRE_DATA and CAP_DATA hold their values until the next operation overwrites them bit by bit. They are valid only from DONE until the next accepted START.
- SD is glitch-free: driven directly from a flop, never from decoded combinational state.
- Counter saturation is not needed; counter compares against CHAIN_LEN-1 and clears on each state change.

Decomposition:
- Shared package scan_pkg: state enum (IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, FIN) and a function computing CNT_W.
- Sub-module scan_shreg: CHAIN_LEN-bit serial-to-parallel collector with a bit-index write.
  - Instantiated twice, once for PRE_DATA and once for CAP_DATA.
- Bench model: CHAIN_LEN instances of the existing mux-scan flop cell in series, with per-position D0 driven from the testbench.

Test Plan:
- CHAIN_LEN=8, chain preset to 8'hA5 by a prior operation, LOAD_DATA=8'h3C, functional D0=8'h00 -> PRE_DATA=8'hA5 (bit-reversal per the index rule checked), CAP_DATA=8'h00, DONE exactly 18 cycles after START.
- LOAD_DATA=8'hFF, D0 pattern 8'h81 -> CAP_DATA=8'h81; SD low in exactly one cycle between the two shift phases; SI=0 throughout SHIFT_OUT.
- Back-to-back operations: START asserted every cycle -> one DONE per 19 cycles; no START is accepted while BUSY or in FIN.
- CD asserted for 1 cycle mid-SHIFT_IN (k=3) -> SD, BUSY, DONE and the data outputs are 0 immediately (before the next CK edge); the next START runs a full clean operation.
- CHAIN_LEN=2 build: LOAD_DATA=2'b10, D0=2'b01 -> CAP_DATA=2'b01, DONE 6 cycles after START.
- Each cycle, SD and SI change only on a rising CK edge (no glitches, checked by an assertion); BUSY and SD agree with the state table.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared definitions for the scan chain controller.
// Contents:
//   scanState_e : controller states (IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, FIN)
//   cntWidth()  : width of a counter that can hold 0..chainLen
package scan_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SHIFT_IN  = 3'd1,
    CAPTURE   = 3'd2,
    SHIFT_OUT = 3'd3,
    FIN       = 3'd4
  } scanState_e;

  function automatic int cntWidth(input int chainLen);
    return $clog2(chainLen + 1);
  endfunction

endpackage

// File: rtl/scan_shreg.sv
// Serial-to-parallel collector: writes bit_i into data_o[idx_i] on each
// enabled clock edge and holds every other bit.
// Ports:
//   clk_i   : clock, rising edge
//   rst_i   : asynchronous active-high reset, clears the word
//   wrEn_i  : write enable for this cycle
//   idx_i   : bit position to write
//   bit_i   : value written
//   data_o  : collected word
module scan_shreg #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wrEn_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // Index decode is done as a compare per bit so the index may be wider
  // than the natural select width of the word.
  always_comb begin
    data_d = data_q;
    if (wrEn_i) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (idx_i == IDX_W'(i)) begin
          data_d[i] = bit_i;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/scan_chain_ctrl.sv
// Controller for a chain of CHAIN_LEN mux-scan flops. One operation shifts
// LOAD_DATA into the chain while unloading its old contents into PRE_DATA,
// performs one functional capture cycle, then shifts the captured state out
// into CAP_DATA while filling the chain with zeros.
// Ports:
//   CK        : clock, rising edge, shared with the chain
//   CD        : asynchronous active-high reset
//   START     : one-cycle request, honoured only in IDLE
//   LOAD_DATA : pattern to shift in, latched when START is accepted
//   SD        : scan select to the chain (1 = shift, 0 = functional)
//   SI        : scan-in bit to chain position 0
//   SO        : scan-out bit from chain position CHAIN_LEN-1
//   BUSY      : high while shifting or capturing
//   DONE      : one-cycle completion pulse
//   PRE_DATA  : chain contents before the operation (bit k = old position CHAIN_LEN-1-k)
//   CAP_DATA  : chain contents after capture (same indexing)
module scan_chain_ctrl
  import scan_pkg::*;
#(
  parameter int CHAIN_LEN = 16
) (
  input  logic                 CK,
  input  logic                 CD,
  input  logic                 START,
  input  logic [CHAIN_LEN-1:0] LOAD_DATA,
  output logic                 SD,
  output logic                 SI,
  input  logic                 SO,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [CHAIN_LEN-1:0] PRE_DATA,
  output logic [CHAIN_LEN-1:0] CAP_DATA
);

  localparam int               CNT_W    = cntWidth(CHAIN_LEN);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CHAIN_LEN - 1);

  scanState_e           state_q, state_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [CHAIN_LEN-1:0] pattern_q, pattern_d;
  logic                 sd_q, sd_d;
  logic                 si_q, si_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 preWe;
  logic                 capWe;

  always_ff @(posedge CK or posedge CD) begin
    if (CD) begin
      state_q   <= IDLE;
      count_q   <= '0;
      pattern_q <= '0;
      sd_q      <= 1'b0;
      si_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      pattern_q <= pattern_d;
      sd_q      <= sd_d;
      si_q      <= si_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // The pattern register shifts right once per SHIFT_IN cycle, so bit 0 is
  // always the next bit to present on SI. All outputs are decoded from the
  // next state and registered, which keeps SD/SI stable for a whole cycle.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    pattern_d = pattern_q;

    case (state_q)
      IDLE: begin
        if (START) begin
          state_d   = SHIFT_IN;
          count_d   = '0;
          pattern_d = LOAD_DATA;
        end
      end
      SHIFT_IN: begin
        pattern_d = pattern_q >> 1;
        if (count_q == LAST_IDX) begin
          state_d = CAPTURE;
          count_d = '0;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      CAPTURE: begin
        state_d = SHIFT_OUT;
        count_d = '0;
      end
      SHIFT_OUT: begin
        if (count_q == LAST_IDX) begin
          state_d = FIN;
          count_d = '0;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      FIN: begin
        state_d = IDLE;
        count_d = '0;
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase

    sd_d   = (state_d == SHIFT_IN) || (state_d == SHIFT_OUT);
    busy_d = sd_d || (state_d == CAPTURE);
    done_d = (state_d == FIN);
    si_d   = (state_d == SHIFT_IN) ? pattern_d[0] : 1'b0;
  end

  assign preWe = (state_q == SHIFT_IN);
  assign capWe = (state_q == SHIFT_OUT);

  scan_shreg #(
    .WIDTH (CHAIN_LEN),
    .IDX_W (CNT_W)
  ) u_preShreg (
    .clk_i  (CK),
    .rst_i  (CD),
    .wrEn_i (preWe),
    .idx_i  (count_q),
    .bit_i  (SO),
    .data_o (PRE_DATA)
  );

  scan_shreg #(
    .WIDTH (CHAIN_LEN),
    .IDX_W (CNT_W)
  ) u_capShreg (
    .clk_i  (CK),
    .rst_i  (CD),
    .wrEn_i (capWe),
    .idx_i  (count_q),
    .bit_i  (SO),
    .data_o (CAP_DATA)
  );

  assign SD   = sd_q;
  assign SI   = si_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Directed bench for scan_chain_ctrl with an 8-flop and a 2-flop chain.
// Each chain is a behavioural model of mux-scan flops in series. The
// functional word d0Word feeds position CHAIN_LEN-1-k from bit k, so a
// captured word reads back unchanged in CAP_DATA. Chain preset loads
// physical positions directly (bit i -> position i) on the START edge.
module tb_scan_chain_ctrl;

  logic       ck;
  logic       cd;

  logic       start8;
  logic [7:0] load8;
  logic       sd8, si8, so8, busy8, done8;
  logic [7:0] pre8, cap8;
  logic [7:0] chain8;
  logic [7:0] d0Word8;
  logic       preset8En;
  logic [7:0] preset8Val;

  logic       start2;
  logic [1:0] load2;
  logic       sd2, si2, so2, busy2, done2;
  logic [1:0] pre2, cap2;
  logic [1:0] chain2;
  logic [1:0] d0Word2;

  int         nAsserts;
  int         nFails;
  time        lastEdge;

  logic [7:0] shiftedIn;
  int         doneCount;
  int         doneAt[4];
  int         doneAt2;

  scan_chain_ctrl #(.CHAIN_LEN(8)) dut8 (
    .CK        (ck),
    .CD        (cd),
    .START     (start8),
    .LOAD_DATA (load8),
    .SD        (sd8),
    .SI        (si8),
    .SO        (so8),
    .BUSY      (busy8),
    .DONE      (done8),
    .PRE_DATA  (pre8),
    .CAP_DATA  (cap8)
  );

  scan_chain_ctrl #(.CHAIN_LEN(2)) dut2 (
    .CK        (ck),
    .CD        (cd),
    .START     (start2),
    .LOAD_DATA (load2),
    .SD        (sd2),
    .SI        (si2),
    .SO        (so2),
    .BUSY      (busy2),
    .DONE      (done2),
    .PRE_DATA  (pre2),
    .CAP_DATA  (cap2)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  // Chain models: shift on SD=1, functional load on SD=0, bench preset wins.
  always @(posedge ck) begin
    if (preset8En) begin
      chain8 <= preset8Val;
    end else if (sd8) begin
      chain8 <= {chain8[6:0], si8};
    end else begin
      for (int i = 0; i < 8; i++) chain8[i] <= d0Word8[7-i];
    end
  end
  assign so8 = chain8[7];

  always @(posedge ck) begin
    if (sd2) begin
      chain2 <= {chain2[0], si2};
    end else begin
      chain2[0] <= d0Word2[1];
      chain2[1] <= d0Word2[0];
    end
  end
  assign so2 = chain2[1];

  always @(posedge ck) lastEdge = $time;

  // Outside reset, SD and SI may only move at a rising clock edge.
  always @(sd8 or si8 or sd2 or si2) begin
    if ($time > 0 && !cd) begin
      nAsserts++;
      assert ($time == lastEdge) else begin
        nFails++;
        $error("[TB] FAIL sdSiGlitch: observed change at %0t expected at edge %0t", $time, lastEdge);
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nAsserts++;
    assert (observed === expected) else begin
      nFails++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Runs one full 8-bit operation from IDLE and checks {SD,BUSY,SI,DONE}
  // against the state table every cycle. Returns in the FIN cycle with
  // the chain contents seen during CAPTURE.
  task automatic applyStimulus(input string opName, input logic [7:0] load, input logic [7:0] d0w,
                               input logic doPreset, input logic [7:0] presetV,
                               output logic [7:0] chainAtCapture);
    logic sdE, busyE, siE, doneE;
    @(posedge ck); #1;
    load8      = load;
    d0Word8    = d0w;
    preset8En  = doPreset;
    preset8Val = presetV;
    start8     = 1'b1;
    @(posedge ck); #1;
    start8    = 1'b0;
    preset8En = 1'b0;
    load8     = ~load;
    chainAtCapture = '0;
    for (int j = 1; j <= 18; j++) begin
      sdE   = (j <= 8) || (j >= 10 && j <= 17);
      busyE = (j <= 17);
      doneE = (j == 18);
      siE   = (j <= 8) ? load[j-1] : 1'b0;
      checkOutput($sformatf("%s cycle%0d {SD,BUSY,SI,DONE}", opName, j),
                  {28'd0, sd8, busy8, si8, done8}, {28'd0, sdE, busyE, siE, doneE});
      if (j == 9) chainAtCapture = chain8;
      if (j < 18) begin
        @(posedge ck); #1;
      end
    end
  endtask

  initial begin
    nAsserts   = 0;
    nFails     = 0;
    cd         = 1'b1;
    start8     = 1'b0;
    load8      = '0;
    d0Word8    = '0;
    preset8En  = 1'b0;
    preset8Val = '0;
    start2     = 1'b0;
    load2      = '0;
    d0Word2    = '0;

    // Reset state
    repeat (3) @(posedge ck);
    #1;
    checkOutput("reset8 {SD,SI,BUSY,DONE}", {28'd0, sd8, si8, busy8, done8}, 32'd0);
    checkOutput("reset8 PRE", pre8, 8'h00);
    checkOutput("reset8 CAP", cap8, 8'h00);
    checkOutput("reset2 {SD,SI,BUSY,DONE}", {28'd0, sd2, si2, busy2, done2}, 32'd0);
    cd = 1'b0;

    // Op1: chain preset A5, load 3C, functional zero
    $display("[TB] op1 preset A5 load 3C");
    applyStimulus("op1", 8'h3C, 8'h00, 1'b1, 8'hA5, shiftedIn);
    checkOutput("op1 chainAfterShiftIn", shiftedIn, 8'h3C);
    checkOutput("op1 PRE", pre8, 8'hA5);
    checkOutput("op1 CAP", cap8, 8'h00);
    checkOutput("op1 chainEnd", chain8, 8'h00);

    // Op2: load FF, functional 81 (also loaded while idle, so PRE sees it)
    $display("[TB] op2 load FF d0 81");
    applyStimulus("op2", 8'hFF, 8'h81, 1'b0, 8'h00, shiftedIn);
    checkOutput("op2 chainAfterShiftIn", shiftedIn, 8'hFF);
    checkOutput("op2 PRE", pre8, 8'h81);
    checkOutput("op2 CAP", cap8, 8'h81);

    // Op3: asymmetric values expose the bit ordering
    $display("[TB] op3 preset 01 load 01 d0 03");
    applyStimulus("op3", 8'h01, 8'h03, 1'b1, 8'h01, shiftedIn);
    checkOutput("op3 chainAfterShiftIn", shiftedIn, 8'h80);
    checkOutput("op3 PRE", pre8, 8'h80);
    checkOutput("op3 CAP", cap8, 8'h03);

    // Back-to-back: START held from the FIN cycle on
    $display("[TB] back-to-back START");
    start8    = 1'b1;
    doneCount = 0;
    for (int cyc = 1; cyc <= 80; cyc++) begin
      @(posedge ck); #1;
      if (done8 === 1'b1) begin
        if (doneCount < 4) doneAt[doneCount] = cyc;
        doneCount++;
      end
      if (cyc == 59) start8 = 1'b0;
    end
    checkOutput("b2b doneCount", doneCount, 4);
    checkOutput("b2b done0", doneAt[0], 19);
    checkOutput("b2b done1", doneAt[1], 38);
    checkOutput("b2b done2", doneAt[2], 57);
    checkOutput("b2b done3", doneAt[3], 76);
    checkOutput("b2b PRE", pre8, 8'h03);

    // Reset in SHIFT_IN at k=3
    $display("[TB] reset mid shift-in");
    @(posedge ck); #1;
    load8   = 8'h5A;
    d0Word8 = 8'hFF;
    start8  = 1'b1;
    @(posedge ck); #1;
    start8 = 1'b0;
    repeat (3) @(posedge ck);
    #1;
    checkOutput("midShift {SD,BUSY}", {30'd0, sd8, busy8}, 32'd3);
    checkOutput("midShift PRE partial", pre8, 8'h07);
    #1 cd = 1'b1;
    #1;
    checkOutput("midShift reset {SD,SI,BUSY,DONE}", {28'd0, sd8, si8, busy8, done8}, 32'd0);
    checkOutput("midShift reset PRE", pre8, 8'h00);
    checkOutput("midShift reset CAP", cap8, 8'h00);
    cd = 1'b0;

    // Clean operation after the reset
    $display("[TB] op4 after reset");
    applyStimulus("op4", 8'hC3, 8'h5A, 1'b0, 8'h00, shiftedIn);
    checkOutput("op4 chainAfterShiftIn", shiftedIn, 8'hC3);
    checkOutput("op4 PRE", pre8, 8'h5A);
    checkOutput("op4 CAP", cap8, 8'h5A);

    // Two-flop chain
    $display("[TB] CHAIN_LEN=2 operation");
    @(posedge ck); #1;
    load2   = 2'b10;
    d0Word2 = 2'b01;
    start2  = 1'b1;
    @(posedge ck); #1;
    start2  = 1'b0;
    load2   = 2'b00;
    doneAt2 = 0;
    for (int j = 1; j <= 10; j++) begin
      if (j == 2) checkOutput("n2 SI k1", {31'd0, si2}, 32'd1);
      if (j == 3) begin
        checkOutput("n2 capture {SD,BUSY}", {30'd0, sd2, busy2}, 32'd1);
        checkOutput("n2 chainAfterShiftIn", chain2, 2'b01);
      end
      if (done2 === 1'b1 && doneAt2 == 0) doneAt2 = j;
      if (j == 6) begin
        checkOutput("n2 PRE", pre2, 2'b01);
        checkOutput("n2 CAP", cap2, 2'b01);
      end
      @(posedge ck); #1;
    end
    checkOutput("n2 doneLatency", doneAt2, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
